instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/ifu_pkg.sv | 28 ++
 rtl/ifu_fifo.sv | 69 ++++++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared types and constants for the instruction fetch unit.
//            Holds the FSM state enum, the word width and the default
//            reset fetch address, plus the word-granular pc increment.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ifu_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [WORD_W-1:0] IFU_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } ifu_state_e;

   // Word-granular increment; wraps FFFF_FFFF -> 0 silently.
   function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
      return pc + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fifo
// Purpose  : Prefetch buffer. DEPTH entries of DATA_W bits, power-of-two
//            depth so the pointers wrap naturally. Synchronous flush
//            empties the buffer and overrides push/pop.
// Ports    : clk_i    - clock
//            rst_i    - synchronous active-high reset
//            flush_i  - discard all entries
//            push_i   - write data_i at the tail
//            data_i   - entry to write
//            pop_i    - drop the head entry
//            data_o   - head entry (zero when empty)
//            valid_o  - buffer holds at least one entry
//            count_o  - number of entries held
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        data_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q;
   logic [AW-1:0]     rptr_q;
   logic [CW-1:0]     count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + AW'(1);
         if (pop_i)  rptr_q <= rptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset: contents are only visible through valid_o.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i && !rst_i) begin
         mem_q[wptr_q] <= data_i;
      end
   end

   assign valid_o = (count_q != '0);
   assign data_o  = valid_o ? mem_q[rptr_q] : '0;
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Read-only instruction prefetcher. Issues sequential word reads
//            to a one-cycle-latency memory, buffers {pc, word} pairs in a
//            DEPTH-entry FIFO and hands them to the consumer with a
//            valid/ready handshake. A redirect pulse discards everything
//            buffered or in flight and restarts at redirect_pc.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            fetch_en                - permits new reads
//            redirect_valid/_pc      - restart fetch at redirect_pc
//            mem_wr, mem_data_in     - tied to zero
//            mem_address             - read address to memory
//            mem_data_out            - read data, one cycle after address
//            instr_valid/_ready      - consumer handshake
//            instr, instr_pc         - buffered word and its address
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [WORD_W-1:0] RESET_PC = IFU_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_pc,
   output logic              mem_wr,
   output logic [WORD_W-1:0] mem_address,
   output logic [WORD_W-1:0] mem_data_in,
   input  logic [WORD_W-1:0] mem_data_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] instr_pc
);

   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned OW  = CW + 1;

   ifu_state_e          state_q, state_d;
   logic [WORD_W-1:0]   pc_q, pc_d;
   logic [WORD_W-1:0]   addr_q, addr_d;
   logic                inflight_q, inflight_d;

   logic [CW-1:0]       w_count;
   logic                w_room;
   logic                w_issue;
   logic                w_push;
   logic                w_pop;
   logic [2*WORD_W-1:0] w_head;

   // Occupancy counts the in-flight read so the buffer can never overflow.
   // Registered values only: a same-cycle pop does not open a slot.
   assign w_room = ({1'b0, w_count} + OW'(inflight_q)) < OW'(DEPTH);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            IDLE, FETCH, FLUSH: state_d = fetch_en ? FETCH : IDLE;
            default:            state_d = IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   // FLUSH always fetches the redirect target, even if fetch_en has dropped;
   // FETCH needs fetch_en to start a new read.
   always_comb begin
      w_issue = 1'b0;
      if (!reset && !redirect_valid && w_room) begin
         case (state_q)
            FETCH:   w_issue = fetch_en;
            FLUSH:   w_issue = 1'b1;
            default: w_issue = 1'b0;
         endcase
      end

      inflight_d = w_issue;
      addr_d     = w_issue ? pc_q : addr_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (w_issue) begin
         pc_d = pc_next(pc_q);
      end else begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
      end
   end

   // addr_q still holds the in-flight address when its data returns,
   // so it tags the pushed word.
   assign w_push = inflight_q && !redirect_valid && !reset;
   assign w_pop  = instr_valid && instr_ready && !redirect_valid;

   ifu_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (2 * WORD_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .flush_i (redirect_valid),
      .push_i  (w_push),
      .data_i  ({addr_q, mem_data_out}),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .valid_o (instr_valid),
      .count_o (w_count)
   );

   assign mem_address = addr_d;
   assign mem_wr      = 1'b0;
   assign mem_data_in = '0;
   assign instr_pc    = w_head[2*WORD_W-1:WORD_W];
   assign instr       = w_head[WORD_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. A queue-level model
//            predicts mem_address and the buffer head every cycle; directed
//            scenarios add literal expectations on delivered words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_wr;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   // second instance: non-zero reset address, wrap-around check
   logic        fetch_en2 = 1'b0;
   logic        mem_wr2;
   logic [31:0] mem_address2;
   logic [31:0] mem_data_in2;
   logic [31:0] mem_data_out2 = '0;
   logic        instr_valid2;
   logic [31:0] instr2;
   logic [31:0] instr_pc2;

   logic [31:0] salt = '0;
   int          checks = 0;
   int          failures = 0;
   bit          chk_on = 1'b0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_wr(mem_wr), .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
   );

   instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFE)) u_dut2 (
      .clk(clk), .reset(reset), .fetch_en(fetch_en2),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .mem_wr(mem_wr2), .mem_address(mem_address2), .mem_data_in(mem_data_in2),
      .mem_data_out(mem_data_out2), .instr_valid(instr_valid2),
      .instr_ready(1'b1), .instr(instr2), .instr_pc(instr_pc2)
   );

   // one-cycle-latency memories: word at address a is a ^ salt
   always @(posedge clk) begin
      mem_data_out  <= mem_address ^ salt;
      mem_data_out2 <= mem_address2;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
      return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   // ------------------------------------------------------------ model
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] w;
   } ent_t;

   ent_t        mq[$];
   int          m_mode = 0;          // 0 idle, 1 fetching, 2 just redirected
   logic [31:0] m_pc = '0;
   logic [31:0] m_last = '0;
   logic [31:0] m_inf_pc = '0;
   bit          m_inf = 1'b0;

   function automatic bit m_issue();
      if (reset || redirect_valid) return 1'b0;
      if (mq.size() + int'(m_inf) >= DEPTH) return 1'b0;
      return (m_mode == 2) || (m_mode == 1 && fetch_en);
   endfunction

   always @(posedge clk) begin : model
      bit iss;
      bit pop;
      iss = m_issue();
      pop = (mq.size() > 0) && instr_ready;
      if (reset) begin
         mq.delete();
         m_mode = 0; m_pc = 32'h0; m_last = 32'h0; m_inf = 1'b0;
      end else if (redirect_valid) begin
         mq.delete();
         m_mode = 2; m_pc = redirect_pc; m_inf = 1'b0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_inf) mq.push_back({m_inf_pc, m_inf_pc ^ salt});
         m_inf = iss;
         if (iss) begin
            m_inf_pc = m_pc;
            m_last   = m_pc;
            m_pc     = m_pc + 32'd1;
         end
         m_mode = fetch_en ? 1 : 0;
      end
   end

   // ---------------------------------------------------------- compare
   always @(negedge clk) begin
      if (chk_on) begin
         chk("mem_wr", 32'(mem_wr), 32'h0);
         chk("mem_data_in", mem_data_in, 32'h0);
         chk("mem_wr2", 32'(mem_wr2), 32'h0);
         chk("mem_address", mem_address, m_issue() ? m_pc : m_last);
         chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
         if (mq.size() > 0) begin
            chk("instr_pc", instr_pc, mq[0].pc);
            chk("instr", instr, mq[0].w);
         end
      end
   end

   // delivered-word logs
   logic [31:0] dlv[$];
   logic [31:0] dlv2[$];
   always @(posedge clk) begin
      if (!reset && instr_valid && instr_ready) dlv.push_back(instr_pc);
      if (!reset && instr_valid2) dlv2.push_back(instr_pc2);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin : stim
      bit found;
      tick();
      chk_on = 1'b1;
      tick();
      reset = 1'b0;

      // reset values
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_addr", mem_address, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);

      // first-word latency, one word per cycle; words equal addresses
      fetch_en = 1'b1; fetch_en2 = 1'b1;
      dlv.delete(); dlv2.delete();
      tick(); chk("lat_c1_valid", 32'(instr_valid), 32'h0);
      tick(); chk("lat_c2_valid", 32'(instr_valid), 32'h0);
      tick(); chk("lat_c3_valid", 32'(instr_valid), 32'h1);
      chk("lat_c3_pc", instr_pc, 32'h0);
      chk("lat_c3_instr", instr, 32'h0);
      tick(); chk("seq_c4_pc", instr_pc, 32'h1); chk("seq_c4_instr", instr, 32'h1);
      tick(); chk("seq_c5_pc", instr_pc, 32'h2);
      repeat (3) tick();
      chk("wrap_0", qat(dlv2, 0), 32'hFFFF_FFFE);
      chk("wrap_1", qat(dlv2, 1), 32'hFFFF_FFFF);
      chk("wrap_2", qat(dlv2, 2), 32'h0000_0000);
      chk("wrap_3", qat(dlv2, 3), 32'h0000_0001);

      // stalled consumer fills the buffer with exactly DEPTH words
      reset = 1'b1; salt = 32'hC0DE_0000; instr_ready = 1'b0; fetch_en2 = 1'b0;
      tick(); tick();
      reset = 1'b0; dlv.delete();
      repeat (11) tick();
      chk("full_valid", 32'(instr_valid), 32'h1);
      chk("full_head_pc", instr_pc, 32'h0);
      chk("full_head_instr", instr, 32'hC0DE_0000);
      chk("full_addr", mem_address, 32'h3);
      instr_ready = 1'b1;
      repeat (7) tick();
      for (int i = 0; i < 5; i++) chk("drain_order", qat(dlv, i), 32'(i));

      // redirect with words buffered and a read in flight
      instr_ready = 1'b0; fetch_en = 1'b1;
      do_reset();
      repeat (3) tick();
      chk("pre_redir_valid", 32'(instr_valid), 32'h1);
      redirect_valid = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      chk("post_redir_valid", 32'(instr_valid), 32'h0);
      dlv.delete();
      repeat (6) tick();
      chk("redir_first", qat(dlv, 0), 32'h40);
      chk("redir_second", qat(dlv, 1), 32'h41);

      // back-to-back redirects: the later target wins
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      dlv.delete();
      repeat (6) tick();
      chk("b2b_first", qat(dlv, 0), 32'h200);
      chk("b2b_second", qat(dlv, 1), 32'h201);

      // fetch_en dropped the cycle after pc 5 is issued
      fetch_en = 1'b1; instr_ready = 1'b1;
      do_reset();
      dlv.delete();
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (m_issue() && m_pc == 32'h5) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("find_issue5", 32'(found), 32'h1);
      tick();
      fetch_en = 1'b0;
      repeat (6) tick();
      chk("stop_count", 32'(dlv.size()), 32'd6);
      chk("stop_last", qat(dlv, 5), 32'h5);
      chk("stop_addr", mem_address, 32'h5);
      fetch_en = 1'b1;
      repeat (6) tick();
      chk("resume_pc6", qat(dlv, 6), 32'h6);

      // reset with two words buffered and one read in flight
      fetch_en = 1'b1; instr_ready = 1'b0;
      do_reset();
      repeat (4) tick();
      chk("pre_rst_valid", 32'(instr_valid), 32'h1);
      chk("pre_rst_pc", instr_pc, 32'h0);
      reset = 1'b1; instr_ready = 1'b1; fetch_en = 1'b0;
      tick();
      reset = 1'b0;
      dlv.delete();
      chk("midrst_valid", 32'(instr_valid), 32'h0);
      chk("midrst_addr", mem_address, 32'h0);
      repeat (3) tick();
      chk("stale_valid", 32'(instr_valid), 32'h0);
      chk("stale_dlv", 32'(dlv.size()), 32'd0);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
